add_pipe: RTL and testbench
===========================

# add_pipe

Parametrised, pipelined two's-complement adder/subtractor, the next generation of the ALU's fixed 16-bit ripple adder. Operands are split into STAGES equal chunks; each pipeline stage adds one chunk and registers its carry forward, so the carry chain per cycle is WIDTH/STAGES bits instead of WIDTH. A valid/ready handshake on both sides gives full throughput with backpressure. The block also produces carry, overflow, zero and negative flags for the CPU's condition logic.

## Interface
- WIDTH, 16: operand and result width in bits.
- STAGES, 4: number of pipeline stages. WIDTH must be a multiple of STAGES; CHUNK = WIDTH/STAGES.
- clk  input  1  the block's single clock; all state updates on its rising edge.
- reset  input  1  asynchronous, active-high reset. It clears all state immediately on assertion, independent of clk.
- in_valid  input  1  the operand set is present.
- in_ready  output  1  the block can accept an operand set this cycle.
- a  input  WIDTH  first operand.
- b  input  WIDTH  second operand.
- sub  input  1  0 selects a+b; 1 selects a−b.
- cin  input  1  carry-in, added at bit 0. Ignored when sub=1, because subtract forces carry-in to 1.
- out_valid  output  1  the result and flags are valid.
- out_ready  input  1  the consumer accepts the result this cycle.
- out  output  WIDTH  sum or difference, modulo 2^WIDTH.
- c_flag  output  1  carry out of the MSB. For subtract, 1 means no borrow.
- v_flag  output  1  signed overflow.
- z_flag  output  1  out == 0.
- n_flag  output  1  out[WIDTH−1].

## Operation
- Transfers:
  - Input transfer occurs when in_valid && in_ready.
  - Output transfer occurs when out_valid && out_ready.
- Subtract: b_eff = sub ? ~b : b; carry-in = sub ? 1 : cin. This is resolved at input capture.
- Stage k (0..STAGES−1) adds chunk k of a and b_eff plus the carry from stage k−1. The carry for stage 0 is the captured carry-in.
- Each stage register holds:
  - valid;
  - the result chunks completed so far;
  - the unprocessed upper chunks of a and b_eff, skewed forward;
  - the carry;
  - a running all-zero bit, ANDed per chunk.
- The last stage also captures c_flag, v_flag, n_flag and z_flag:
  - c_flag = carry out of the MSB.
  - v_flag = carry into the MSB XOR carry out of the MSB.
  - n_flag = out[WIDTH−1].
  - z_flag = running all-zero bit.
- Per-stage handshake, bubble-collapsing:
  - stage_ready[k] = !valid[k] || stage_ready[k+1].
  - stage_ready[STAGES] = out_ready.
  - in_ready = stage_ready[0].
- A stage loads when it is ready. It takes the upstream valid, so bubbles are squeezed out while the output is stalled.
- A stalled stage holds all of its contents unchanged.
- out and all flags are registered outputs of the last stage. They stay stable while out_valid && !out_ready.
- Results leave in acceptance order. No reordering; nothing is dropped or duplicated.
- Reset (asynchronous, any time, including mid-stream):
  - all valid bits are cleared, so in-flight operations are discarded;
  - out and all flags are cleared to 0.
- After reset is released:
  - out_valid=0, out=0, all flags 0;
  - in_ready=1 from the first cycle.
- STAGES=1 degenerates to a single registered adder with latency 1.

## Timing
- Latency: operands accepted at rising edge t produce out_valid=1 after edge t+STAGES−1. That is STAGES cycles with no stall.
- Throughput: one operation per cycle while out_ready=1.
- Capacity: STAGES operations in flight. With out_ready=0 held, in_ready falls only once all STAGES stages are valid.
- Simultaneous events in one cycle:
  - a full pipeline that is both accepting input and delivering output keeps in_ready=1;
  - in_ready depends combinationally on out_ready;
  - the adder has no internal combinational path from in_valid to out_valid.
- Critical path per stage: a CHUNK-bit ripple add plus handshake logic.

## Test plan
- All tests use WIDTH=16, STAGES=4, unless noted.
- Basic add and flags: a=0x7FFF, b=0x0001, sub=0, cin=0 → 4 cycles later out=0x8000, v=1, c=0, n=1, z=0.
- Carry chain and zero: a=0xFFFF, b=0x0001 → out=0x0000, c=1, z=1, v=0. Then a=0x00FF, b=0x0001, cin=1 → out=0x0101, showing carry crossing a chunk boundary.
- Subtract: a=0x0005, b=0x0007, sub=1 → out=0xFFFE, c=0, n=1. Then a=0x8000, b=0x0001, sub=1 → out=0x7FFF, v=1, c=1.
- Backpressure: stream 8 random operations with out_ready toggling on a pseudo-random pattern → the results match a reference model in order, each exactly once; out is stable during every stall; in_ready=0 only when 4 are in flight.
- Reset mid-stream: assert reset between clock edges with 3 operations in flight → out_valid=0 and out and flags are 0 immediately. No stale result appears after release, and the first new operation returns with latency 4.
- Parameter sweep: run WIDTH=32, STAGES=2 and WIDTH=8, STAGES=1 with 1000 random add/sub operations each → all results and flags match the model; latency is STAGES.

Source files
------------

// File: rtl/add_pipe.sv
// add_pipe: pipelined two's-complement adder/subtractor with valid/ready
// handshaking on both sides.
//
// The operands are cut into STAGES chunks of CHUNK = WIDTH/STAGES bits.
// Stage k adds chunk k and registers the carry for stage k+1, so each
// cycle's carry chain is only CHUNK bits long. Subtraction is folded in when
// the operands are captured: b is inverted and the carry-in is forced to 1.
//
// Parameters
//   WIDTH   operand/result width (must be a multiple of STAGES)
//   STAGES  pipeline depth; latency is STAGES cycles without stalls
//
// Ports
//   clk        clock, rising edge
//   reset      asynchronous active-high reset; discards in-flight work
//   in_valid   operand set present            in_ready   stage 0 can load
//   a, b       operands                       sub        1: a-b, 0: a+b
//   cin        carry-in for add (ignored for sub)
//   out_valid  result present                 out_ready  consumer accepts
//   out        result modulo 2^WIDTH
//   c_flag     carry out of MSB (for sub: 1 = no borrow)
//   v_flag     signed overflow
//   z_flag     out == 0
//   n_flag     out[WIDTH-1]
module add_pipe #(
  parameter int WIDTH  = 16,
  parameter int STAGES = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out,
  output logic             c_flag,
  output logic             v_flag,
  output logic             z_flag,
  output logic             n_flag
);

  localparam int CHUNK = WIDTH / STAGES;
  localparam int L     = STAGES - 1;

  // Stage registers
  logic [STAGES-1:0] vld_q;
  logic [STAGES-1:0] cy_q;
  logic [STAGES-1:0] zr_q;
  logic [WIDTH-1:0]  res_q [STAGES];
  logic [WIDTH-1:0]  opa_q [STAGES];
  logic [WIDTH-1:0]  opb_q [STAGES];
  logic              c_q, v_q, z_q, n_q;

  // Per-stage upstream view and next-state values
  logic [STAGES-1:0] up_vld, up_cy, up_zr, stg_rdy, cy_d, zr_d;
  logic [WIDTH-1:0]  up_a   [STAGES];
  logic [WIDTH-1:0]  up_b   [STAGES];
  logic [WIDTH-1:0]  up_res [STAGES];
  logic [WIDTH-1:0]  res_d  [STAGES];
  logic [CHUNK:0]    sum_d  [STAGES];
  logic              c_d, v_d, z_d, n_d;

  always_comb begin
    // Stage 0 is fed straight from the ports with subtract already resolved.
    up_vld[0] = in_valid;
    up_a[0]   = a;
    up_b[0]   = sub ? ~b : b;
    up_cy[0]  = sub | cin;
    up_res[0] = '0;
    up_zr[0]  = 1'b1;
    for (int k = 1; k < STAGES; k++) begin
      up_vld[k] = vld_q[k-1];
      up_a[k]   = opa_q[k-1];
      up_b[k]   = opb_q[k-1];
      up_cy[k]  = cy_q[k-1];
      up_res[k] = res_q[k-1];
      up_zr[k]  = zr_q[k-1];
    end

    // A stage can load if it is empty or anything downstream of it is empty
    // or the consumer is taking the result; this is the unrolled form of
    // ready[k] = !valid[k] || ready[k+1] and lets bubbles collapse.
    for (int k = 0; k < STAGES; k++) begin
      stg_rdy[k] = out_ready;
      for (int j = k; j < STAGES; j++) begin
        if (!vld_q[j]) stg_rdy[k] = 1'b1;
      end
    end

    for (int k = 0; k < STAGES; k++) begin
      sum_d[k] = {1'b0, up_a[k][k*CHUNK +: CHUNK]}
               + {1'b0, up_b[k][k*CHUNK +: CHUNK]}
               + {{CHUNK{1'b0}}, up_cy[k]};
      res_d[k] = up_res[k];
      res_d[k][k*CHUNK +: CHUNK] = sum_d[k][CHUNK-1:0];
      cy_d[k]  = sum_d[k][CHUNK];
      zr_d[k]  = up_zr[k] & (sum_d[k][CHUNK-1:0] == '0);
    end

    // Carry into the MSB is recovered from the MSB sum bit and its operands.
    c_d = cy_d[L];
    v_d = cy_d[L] ^ (up_a[L][WIDTH-1] ^ up_b[L][WIDTH-1] ^ sum_d[L][CHUNK-1]);
    n_d = sum_d[L][CHUNK-1];
    z_d = zr_d[L];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vld_q <= '0;
      cy_q  <= '0;
      zr_q  <= '0;
      for (int k = 0; k < STAGES; k++) begin
        res_q[k] <= '0;
        opa_q[k] <= '0;
        opb_q[k] <= '0;
      end
      c_q <= 1'b0;
      v_q <= 1'b0;
      z_q <= 1'b0;
      n_q <= 1'b0;
    end else begin
      for (int k = 0; k < STAGES; k++) begin
        // Stage k boundary: a ready stage takes the upstream valid; data is
        // only replaced by a real operation so the last result stays on out.
        if (stg_rdy[k]) begin
          vld_q[k] <= up_vld[k];
          if (up_vld[k]) begin
            res_q[k] <= res_d[k];
            opa_q[k] <= up_a[k];
            opb_q[k] <= up_b[k];
            cy_q[k]  <= cy_d[k];
            zr_q[k]  <= zr_d[k];
          end
        end
      end
      // Output stage boundary: flags travel with the final stage.
      if (stg_rdy[L] && up_vld[L]) begin
        c_q <= c_d;
        v_q <= v_d;
        z_q <= z_d;
        n_q <= n_d;
      end
    end
  end

  assign in_ready  = stg_rdy[0];
  assign out_valid = vld_q[L];
  assign out       = res_q[L];
  assign c_flag    = c_q;
  assign v_flag    = v_q;
  assign z_flag    = z_q;
  assign n_flag    = n_q;

endmodule

// File: tb/tb_add_pipe.sv
// Bench for add_pipe: directed add/sub/flag cases, a backpressured random
// stream, mid-stream asynchronous reset, and a random sweep over two other
// parameter sets (32/2 and 8/1), all against an arithmetic reference model.
module tb_add_pipe;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Main instance, WIDTH=16 STAGES=4
  logic        reset, in_valid, in_ready, sub, cin, out_valid, out_ready;
  logic        c_flag, v_flag, z_flag, n_flag;
  logic [15:0] a, b, out;

  add_pipe #(.WIDTH(16), .STAGES(4)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .sub(sub), .cin(cin), .out_valid(out_valid),
    .out_ready(out_ready), .out(out), .c_flag(c_flag), .v_flag(v_flag),
    .z_flag(z_flag), .n_flag(n_flag));

  // Sweep instances share one stimulus stream
  logic        s_valid, s_sub, s_cin, s_ordy;
  logic [31:0] s_a, s_b;
  logic        r32, ov32, c32, v32, z32, n32;
  logic [31:0] o32;
  logic        r8, ov8, c8, v8, z8, n8;
  logic [7:0]  o8;

  add_pipe #(.WIDTH(32), .STAGES(2)) u32 (
    .clk(clk), .reset(reset), .in_valid(s_valid), .in_ready(r32),
    .a(s_a), .b(s_b), .sub(s_sub), .cin(s_cin), .out_valid(ov32),
    .out_ready(s_ordy), .out(o32), .c_flag(c32), .v_flag(v32),
    .z_flag(z32), .n_flag(n32));

  add_pipe #(.WIDTH(8), .STAGES(1)) u8 (
    .clk(clk), .reset(reset), .in_valid(s_valid), .in_ready(r8),
    .a(s_a[7:0]), .b(s_b[7:0]), .sub(s_sub), .cin(s_cin), .out_valid(ov8),
    .out_ready(s_ordy), .out(o8), .c_flag(c8), .v_flag(v8),
    .z_flag(z8), .n_flag(n8));

  typedef struct {
    logic [35:0] e;
    int          cyc;
  } ent_t;

  ent_t q16[$];
  ent_t q32[$];
  ent_t q8[$];

  // Reference: {c, v, z, n, result} from plain integer arithmetic.
  function automatic logic [35:0] model(input int w, input logic [31:0] ta,
                                        input logic [31:0] tb_, input logic ts,
                                        input logic tc);
    longint one, m, ua, ub, sa, sb, s, sr, lo, hi;
    logic c, v, z, n;
    logic [31:0] o;
    one = 1;
    m   = (one << w) - 1;
    ua  = {32'h0, ta} & m;
    ub  = {32'h0, tb_} & m;
    sa  = (ua >= (one << (w - 1))) ? ua - (one << w) : ua;
    sb  = (ub >= (one << (w - 1))) ? ub - (one << w) : ub;
    if (ts) begin
      s  = ua - ub;
      c  = (ua >= ub);
      sr = sa - sb;
    end else begin
      s  = ua + ub + longint'(tc);
      c  = ((s >> w) & one) == one;
      sr = sa + sb + longint'(tc);
    end
    lo = -(one << (w - 1));
    hi = (one << (w - 1)) - 1;
    v  = (sr < lo) || (sr > hi);
    o  = 32'(s & m);
    z  = (o == 32'h0);
    n  = o[w-1];
    return {c, v, z, n, o};
  endfunction

  function automatic logic [35:0] obs16();
    return {c_flag, v_flag, z_flag, n_flag, 16'h0, out};
  endfunction

  task automatic chk(input string tag, input logic [35:0] obs, input logic [35:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One isolated operation on the 16/4 instance: checks acceptance,
  // latency (STAGES cycles) and the result/flags.
  task automatic run_one(input logic [15:0] ta, input logic [15:0] tb_,
                         input logic ts, input logic tc,
                         input logic [35:0] exp, input string tag);
    int lat;
    @(negedge clk);
    a = ta; b = tb_; sub = ts; cin = tc; in_valid = 1'b1; out_ready = 1'b1;
    #1 chk({tag, "_rdy"}, 36'(in_ready), 36'(1));
    @(negedge clk);
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    chk({tag, "_lat"}, 36'(lat), 36'(4));
    chk(tag, obs16(), exp);
    @(negedge clk);
  endtask

  initial begin
    ent_t e;
    int   sent, got, inflight, cyc;
    logic took, prev_stall;
    logic [35:0] prev_obs;

    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    a = '0; b = '0; sub = 1'b0; cin = 1'b0;
    s_valid = 1'b0; s_sub = 1'b0; s_cin = 1'b0; s_ordy = 1'b1; s_a = '0; s_b = '0;

    #1;
    chk("rst_vld", 36'(out_valid), 36'(0));
    chk("rst_out", obs16(), 36'(0));
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("post_rst_ready", 36'(in_ready), 36'(1));
    chk("post_rst_vld", 36'(out_valid), 36'(0));
    chk("post_rst_out", obs16(), 36'(0));

    // Directed arithmetic and flag cases
    run_one(16'h7FFF, 16'h0001, 1'b0, 1'b0, {4'b0101, 32'h0000_8000}, "add_ovf");
    run_one(16'hFFFF, 16'h0001, 1'b0, 1'b0, {4'b1010, 32'h0000_0000}, "add_zero");
    run_one(16'h00FF, 16'h0001, 1'b0, 1'b1, {4'b0000, 32'h0000_0101}, "add_cin");
    run_one(16'h0005, 16'h0007, 1'b1, 1'b0, {4'b0001, 32'h0000_FFFE}, "sub_borrow");
    run_one(16'h8000, 16'h0001, 1'b1, 1'b1, {4'b1100, 32'h0000_7FFF}, "sub_ovf");

    // Backpressured random stream of 8 operations
    sent = 0; got = 0; inflight = 0; cyc = 0; took = 1'b0; prev_stall = 1'b0;
    prev_obs = '0;
    while (got < 8 && cyc < 400) begin
      @(negedge clk);
      cyc++;
      if (took) in_valid = 1'b0;
      took = 1'b0;
      if (prev_stall) begin
        chk("bp_hold_vld", 36'(out_valid), 36'(1));
        chk("bp_hold", obs16(), prev_obs);
      end
      out_ready = ($urandom_range(0, 99) < 40);
      if (!in_valid && sent < 8) begin
        a = 16'($urandom); b = 16'($urandom);
        sub = 1'($urandom); cin = 1'($urandom);
        in_valid = 1'b1;
      end
      #1;
      chk("bp_in_ready", 36'(in_ready), 36'((inflight < 4) || out_ready));
      if (out_valid && out_ready) begin
        if (q16.size() == 0) begin
          chk("bp_extra_result", 36'(out_valid), 36'(0));
        end else begin
          e = q16.pop_front();
          chk("bp_data", obs16(), e.e);
          got++;
          inflight--;
        end
      end
      if (in_valid && in_ready) begin
        q16.push_back(ent_t'{model(16, {16'h0, a}, {16'h0, b}, sub, cin), cyc});
        sent++;
        inflight++;
        took = 1'b1;
      end
      prev_stall = out_valid && !out_ready;
      prev_obs   = obs16();
    end
    chk("bp_count", 36'(got), 36'(8));
    @(negedge clk);
    in_valid = 1'b0; out_ready = 1'b1;
    @(negedge clk);

    // Reset with three operations in flight
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      a = 16'h1234 + 16'(i); b = 16'h1111; sub = 1'b0; cin = 1'b0; in_valid = 1'b1;
      @(negedge clk);
    end
    in_valid = 1'b0;
    @(negedge clk);
    chk("mid_pre_vld", 36'(out_valid), 36'(1));
    #2 reset = 1'b1;
    #1;
    chk("mid_rst_vld", 36'(out_valid), 36'(0));
    chk("mid_rst_out", obs16(), 36'(0));
    @(negedge clk);
    reset = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("mid_no_stale", 36'(out_valid), 36'(0));
    end
    run_one(16'h0101, 16'h0202, 1'b0, 1'b0, {4'b0000, 32'h0000_0303}, "after_rst");

    // Parameter sweep: 32/2 and 8/1 fed the same random stream
    cyc = 0;
    for (int i = 0; i < 1006; i++) begin
      @(negedge clk);
      cyc++;
      if (ov32) begin
        if (q32.size() == 0) chk("sw32_extra", 36'(ov32), 36'(0));
        else begin
          e = q32.pop_front();
          chk("sw32_data", {c32, v32, z32, n32, o32}, e.e);
          chk("sw32_lat", 36'(cyc - e.cyc), 36'(2));
        end
      end
      if (ov8) begin
        if (q8.size() == 0) chk("sw8_extra", 36'(ov8), 36'(0));
        else begin
          e = q8.pop_front();
          chk("sw8_data", {c8, v8, z8, n8, 24'h0, o8}, e.e);
          chk("sw8_lat", 36'(cyc - e.cyc), 36'(1));
        end
      end
      s_valid = (i < 1000);
      s_a = $urandom; s_b = $urandom;
      s_sub = 1'($urandom); s_cin = 1'($urandom);
      if ((i % 7) == 0) s_b = s_a;
      #1;
      chk("sw_ready", 36'({r32, r8}), 36'(2'b11));
      if (s_valid) begin
        q32.push_back(ent_t'{model(32, s_a, s_b, s_sub, s_cin), cyc});
        q8.push_back(ent_t'{model(8, s_a, s_b, s_sub, s_cin), cyc});
      end
    end
    chk("sw32_drained", 36'(q32.size()), 36'(0));
    chk("sw8_drained", 36'(q8.size()), 36'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
